dmem_resp: RTL
==============

# dmem_resp

Wait-state data-memory responder for the pipelined ARM core: the memory end of the core's Memory-stage interface (write enable, address, write data out; read data in). It accepts one word access per request, holds it for a programmable number of wait cycles, then completes it. A `busy` stall output lets the core's hazard unit freeze the pipeline until the access completes. It replaces the zero-latency data memory when multi-cycle memory timing is exercised.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, 4..4096.
- `LATENCY`, 2: wait cycles per access; 1..15.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `we`  in  1  write request (core MemWriteM).
- `re`  in  1  read request (core MemtoReg/load in M stage).
- `a`  in  32  byte address (core ALUOutM).
- `wd`  in  32  write data (core WriteDataM).
- `rd`  out  32  read data, registered; valid while `done`=1.
- `busy`  out  1  stall request to core; combinational.
- `done`  out  1  one-cycle completion pulse.

## Operation
- `req` = `we` | `re`. Word index = `a[log2(DEPTH)+1:2]`; bits [1:0] and bits above the index are ignored (aliasing/wrap, no error).
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if `req`, latch index, `wd`, `we` into request registers; load counter with `LATENCY`; go to WAIT. Otherwise stay.
  - WAIT: decrement counter each cycle. In the cycle the counter equals 1, perform the access at the clock edge: on write, `mem[idx] <= wd_latched` and `rd <= wd_latched`; on read, `rd <= mem[idx]`. Go to DONE.
  - DONE: `done`=1, `busy`=0; go to IDLE unconditionally. `req` still high in DONE is the same instruction and must not be re-accepted.
- `busy` = (IDLE & `req`) | WAIT. Zero in DONE and when idle.
- `we`&`re` together: treated as a write; `rd` returns the written word.
- Changes to `a`, `wd`, `we` or `re` during WAIT are ignored; the latched request completes.
- Memory array is not reset; contents after reset are undefined until written.

## Timing
- Request seen in cycle 0 (IDLE). WAIT occupies cycles 1..`LATENCY`. The access commits at the end of cycle `LATENCY`. DONE is cycle `LATENCY`+1, with `rd` valid and `busy`=0.
- The core stalls for `LATENCY`+1 cycles and advances at the end of the DONE cycle.
- Back-to-back: a new `req` in the cycle after DONE is accepted in IDLE normally, giving a minimum issue interval of `LATENCY`+2 cycles.
- Reset: state IDLE, counter 0, `rd`=0, `done`=0, request registers 0. `busy`=0 while `reset` is high regardless of `req`.
- Reset mid-WAIT aborts the access. A pending write is discarded, and the memory word keeps its old value.
- Reset asserted in the DONE cycle forces `done` to 0 immediately.

## Structure
- Shared package `dmem_resp_pkg`: state enum (IDLE/WAIT/DONE), `WORD_W`=32, counter width constant (4 bits).
- One sub-module, `dmem_array`: synchronous-write, synchronous-read word RAM (`DEPTH` × 32) with a single port. The FSM, counter, request latches and `busy`/`done` logic stay in `dmem_resp`.

## Test plan
- Reset with `we`=1 held: `busy`=0, `done`=0, `rd`=0. After release, IDLE accepts the write in the next cycle.
- `LATENCY`=2, write 0xDEADBEEF to 0x40 at cycle 0: `busy`=1 in cycles 0–2, `done`=1 and `rd`=0xDEADBEEF in cycle 3, `busy`=0 in cycle 3. Then read 0x40: `rd`=0xDEADBEEF in that request's DONE cycle.
- Aliasing: with `DEPTH`=64, write 0x12345678 to 0x104, then read 0x004 and 0x107: both return 0x12345678.
- Input change during WAIT: write 0xAAAA0000 to 0x08, then in cycle 1 change `a`=0x0C and `wd`=0x55: mem[2]=0xAAAA0000 and mem[3] is unchanged.
- Reset mid-operation: mem[5]=0x11. Write 0x22 to 0x14, assert `reset` in cycle 1 (WAIT), release, then read 0x14: returns 0x11.
- `LATENCY`=1 back-to-back: reads at cycles 0 and 3 produce `done` in cycles 2 and 5, with `busy` pattern 1,1,0,1,1,0. `we`&`re` together on 0x20 with `wd`=0x99: `rd`=0x99 and mem[8]=0x99.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared types and constants for the wait-state data-memory
// responder.
//   WORD_W  - data word width
//   CNT_W   - width of the wait-cycle counter (holds LATENCY up to 15)
//   state_e - responder FSM states
package dmem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: Memory-stage data bus between the core and the responder.
//   we   - write request (core -> memory)
//   re   - read request (core -> memory)
//   a    - byte address (core -> memory)
//   wd   - write data (core -> memory)
//   rd   - read data, valid while done is high (memory -> core)
//   busy - stall request to the hazard unit (memory -> core)
//   done - one-cycle completion pulse (memory -> core)
interface dmem_resp_if;
    import dmem_resp_pkg::*;

    logic              we;
    logic              re;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] wd;
    logic [WORD_W-1:0] rd;
    logic              busy;
    logic              done;

    modport master (
        output we, re, a, wd,
        input  rd, busy, done
    );

    modport slave (
        input  we, re, a, wd,
        output rd, busy, done
    );

endinterface

// File: rtl/dmem_resp_array.sv
// dmem_array: single-port DEPTH x WORD_W RAM, synchronous write and
// synchronous read. A write also returns the written word on rdata, so the
// read port always shows the word the last access left in that location.
// The storage itself is not reset; only the output register is.
//   clk   - clock
//   reset - async active-high, clears the output register
//   en    - perform an access at this edge
//   we    - access is a write
//   addr  - word index
//   wdata - write data
//   rdata - registered read data
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rdata_r;

    // Storage write port; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Output register: written word on a write, stored word on a read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (en) begin
            rdata_r <= we ? wdata : mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: wait-state data-memory responder. Accepts one word access per
// request, holds it for LATENCY wait cycles, commits it, then pulses done
// for one cycle. busy stalls the core from the request cycle until the
// access completes.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - Memory-stage data bus (we/re/a/wd in, rd/busy/done out)
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    dmem_resp_if.slave  bus
);

    localparam int               IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_e            state_r;
    state_e            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] wd_r;
    logic              we_r;
    logic              done_r;

    logic              req_s;
    logic              accept_s;
    logic              commit_s;
    logic              busy_s;
    logic [IDX_W-1:0]  idx_s;
    logic [WORD_W-1:0] rdata_s;
    logic              unused_a_s;

    assign req_s = bus.we | bus.re;

    // Byte offset and address bits above the array simply alias.
    assign idx_s      = bus.a[IDX_W+1:2];
    assign unused_a_s = ^{bus.a[WORD_W-1:IDX_W+2], bus.a[1:0]};

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic. DONE always returns to IDLE so a request still
    // held high during DONE (same instruction) is not accepted twice.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: request capture, access commit and stall.
    always_comb begin
        accept_s = 1'b0;
        commit_s = 1'b0;
        busy_s   = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = req_s;
                busy_s   = req_s;
            end
            WAIT: begin
                busy_s   = 1'b1;
                commit_s = (cnt_r == CNT_ONE);
            end
            DONE: begin
                busy_s   = 1'b0;
            end
            default: begin
                busy_s   = 1'b0;
            end
        endcase
    end

    // Request latches and wait counter; inputs are ignored once accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            idx_r <= '0;
            wd_r  <= '0;
            we_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= LAT_C;
            idx_r <= idx_s;
            wd_r  <= bus.wd;
            we_r  <= bus.we;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Completion pulse, high exactly in the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_next_s == DONE);
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (commit_s),
        .we    (we_r),
        .addr  (idx_r),
        .wdata (wd_r),
        .rdata (rdata_s)
    );

    // Stall is forced low while reset is held, whatever the request lines do.
    assign bus.busy = busy_s & ~reset;
    assign bus.done = done_r;
    assign bus.rd   = rdata_s;

endmodule
